snn_spike_sink: RTL and testbench
=================================

// Module: snn_spike_sink
// PURPOSE
//  AXI4-Stream receiver for the SNN neuron-data output stream, the consuming end of the spike stream the
//  SNN core emits.
//  Each beat carries one time step: one spike bit per neuron in tdata and the time-step index in tuser.
//  The block checks step sequencing and accumulates per-neuron spike counts plus a global spike total.
//  Host/testbench logic reads the counts back through a simple registered read port.
// PARAMETERS
//  N   32                          neurons per block
//  T   1                           number of blocks; neuron count NT = N*T
//  TS  29302                       time steps per run; the last valid tuser value
//  NN  ceil(N*T/8)                 tdata width in bytes
//  NU  $clog2(TS+1)                tuser width
//  CW  16                          per-neuron counter width, saturating
//  AW  max($clog2(N*T),1)          read address width
// PORTS
//  aclk           in   1       clock; all logic is on the rising edge
//  aresetn        in   1       asynchronous active-low reset
//  s_axis_tdata   in   NN*8    spike vector; bit i = neuron i; bits >= N*T are ignored
//  s_axis_tuser   in   NU      time-step index; the first step is 1
//  s_axis_tlast   in   1       final beat of the run
//  s_axis_tvalid  in   1       beat valid
//  s_axis_tready  out  1       sink ready
//  clear          in   1       synchronous pulse: zero all counts and status, then restart
//  rd_en          in   1       count read request
//  rd_addr        in   AW      neuron index to read; out of range (>= N*T) returns 0
//  rd_data        out  CW      count of neuron rd_addr
//  rd_valid       out  1       rd_data valid, asserted exactly 1 cycle after rd_en
//  step_count     out  NU      tuser of the last accepted beat (0 = none)
//  total_spikes   out  32      sum of all accepted spike bits, saturating at 2^32-1
//  seq_error      out  1       sticky; a beat arrived with tuser != step_count+1
//  done           out  1       run complete
// BEHAVIOUR
//  Reset state (aresetn=0, asynchronous): state=RUN; all counters, step_count, total_spikes = 0;
//   seq_error, done, rd_valid = 0; rd_data = 0.
//  FSM states: RUN, DONE, CLR.
//   RUN: s_axis_tready = !clear (combinational). Handshake = tvalid & tready.
//   RUN -> DONE on a handshake with tlast=1 or tuser==TS.
//   any state -> CLR when clear=1. clear takes priority; no beat is accepted in that cycle.
//   CLR: tready=0 for one cycle. Zeroes counters, step_count, total_spikes, seq_error and done.
//   CLR -> RUN on the next cycle.
//   DONE: tready=0; done=1; stays until clear or reset.
//  On each handshake, updated at the same clock edge:
//   - cnt[i] += tdata[i] for every i < N*T, saturating at 2^CW-1. The popcount uses only the
//     N*T valid bits.
//   - total_spikes += popcount, saturating.
//   - if tuser != step_count+1, set seq_error (sticky). The beat is still counted and
//     step_count := tuser.
//   - a beat with tuser=0 or tuser>TS is also a sequence error.
//  tdata, tuser and tlast are sampled only on a handshake; while tvalid=0 the block holds state.
//  Read port: rd_en registered. rd_data/rd_valid appear at cycle+1.
//   rd_data returns the value before any update at the same edge (read-before-write).
//   Reads are legal in every state; in CLR the read returns the pre-clear value.
//  rd_valid=0 in any cycle without a rd_en in the previous cycle. Back-to-back reads give one result
//   per cycle.
//  An async reset mid-run drops all state immediately. A beat in flight during reset is lost.
//   The sender must restart at tuser=1.
// TESTING
//  1 Reset, then 3 beats: tuser=1,2,3 (tlast on 3), tdata=0x1,0x3,0x80000001 ->
//    cnt[0]=3, cnt[1]=1, cnt[31]=1, total=5, step_count=3, done=1, tready=0, seq_error=0.
//  2 Beats tuser=1,2,4 -> seq_error=1 after the third handshake; all three beats are counted;
//    step_count=4; then clear -> seq_error=0, counts=0, tready=1 two cycles later.
//  3 Stream tdata=0x1 for 70000 steps (TS raised accordingly) -> cnt[0] saturates at 65535 and
//    total keeps growing to 70000.
//  4 clear asserted on the same cycle as tvalid=1 -> tready=0 that cycle, the beat is not counted,
//    and the sender's held beat is accepted after CLR.
//  5 rd_en with rd_addr=0 in the same cycle as a handshake carrying bit0 -> rd_data shows the old
//    value; a read the next cycle shows +1. rd_addr=40 (N*T=32) -> 0.
//  6 Random tvalid gaps plus 10 random tdata beats -> counts and total match the scoreboard;
//    aresetn pulse mid-run -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/snn_spike_sink.sv
// snn_spike_sink: AXI4-Stream consumer for the SNN spike stream.
// One beat = one time step (spike vector in tdata, step index in tuser).
// Accumulates saturating per-neuron spike counts and a global spike total,
// flags out-of-sequence steps, and exposes counts through a registered read port.
module snn_spike_sink #(
    parameter int N  = 32,
    parameter int T  = 1,
    parameter int TS = 29302,
    parameter int NN = (N * T + 7) / 8,
    parameter int NU = $clog2(TS + 1),
    parameter int CW = 16,
    parameter int AW = (N * T > 1) ? $clog2(N * T) : 1
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [NN*8-1:0] s_axis_tdata,
    input  logic [NU-1:0]   s_axis_tuser,
    input  logic            s_axis_tlast,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    input  logic            clear,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [CW-1:0]   rd_data,
    output logic            rd_valid,
    output logic [NU-1:0]   step_count,
    output logic [31:0]     total_spikes,
    output logic            seq_error,
    output logic            done
);

    localparam int NT = N * T;
    localparam int PW = $clog2(NT + 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DONE = 2'd1,
        CLR  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            hs;
    logic [PW-1:0]   pop;
    logic [NU:0]     step_next;
    logic            seq_bad;
    logic [32:0]     total_sum;
    logic [CW-1:0]   rd_word;
    logic [CW-1:0]   cnt [NT];

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake control; clear overrides everything
    always_comb begin
        state_d       = state_q;
        s_axis_tready = 1'b0;
        hs            = 1'b0;
        case (state_q)
            RUN: begin
                s_axis_tready = !clear;
                hs            = s_axis_tvalid && !clear;
                if (hs && (s_axis_tlast || (s_axis_tuser == NU'(TS)))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            CLR:     state_d = RUN;
            default: state_d = RUN;
        endcase
        if (clear) begin
            state_d = CLR;
        end
    end

    assign done = (state_q == DONE);

    // Popcount over the valid neuron bits and sequence/total arithmetic
    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < NT; i++) begin
            pop = pop + PW'(s_axis_tdata[i]);
        end
        step_next = {1'b0, step_count} + (NU + 1)'(1);
        seq_bad   = ({1'b0, s_axis_tuser} != step_next) ||
                    (s_axis_tuser == '0) ||
                    ({1'b0, s_axis_tuser} > (NU + 1)'(TS));
        total_sum = {1'b0, total_spikes} + 33'(pop);
    end

    // Per-neuron saturating counters; zeroed on leaving CLR so reads in CLR see old values
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < NT; i++) begin
                cnt[i] <= '0;
            end
        end else if (state_q == CLR) begin
            for (int unsigned i = 0; i < NT; i++) begin
                cnt[i] <= '0;
            end
        end else if (hs) begin
            for (int unsigned i = 0; i < NT; i++) begin
                if (s_axis_tdata[i] && (cnt[i] != '1)) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Step tracking, sticky sequence error and saturating spike total
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            step_count   <= '0;
            total_spikes <= '0;
            seq_error    <= 1'b0;
        end else if (state_q == CLR) begin
            step_count   <= '0;
            total_spikes <= '0;
            seq_error    <= 1'b0;
        end else if (hs) begin
            step_count   <= s_axis_tuser;
            total_spikes <= total_sum[32] ? '1 : total_sum[31:0];
            if (seq_bad) begin
                seq_error <= 1'b1;
            end
        end
    end

    // Read mux; out-of-range addresses return zero
    always_comb begin
        rd_word = '0;
        if (int'(rd_addr) < NT) begin
            rd_word = cnt[rd_addr];
        end
    end

    // Registered read port, read-before-write against same-edge counter updates
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_snn_spike_sink.sv
// tb_snn_spike_sink: directed bench for snn_spike_sink with a read-data scoreboard.
// Main instance uses default parameters; a small instance (N=20, TS=300, CW=8)
// covers counter saturation, the tuser==TS termination and out-of-range reads.
module tb_snn_spike_sink;

    logic        aclk = 1'b0;
    logic        aresetn;
    always #5 aclk = ~aclk;

    // main instance signals
    logic [31:0] s_tdata;
    logic [14:0] s_tuser;
    logic        s_tlast, s_tvalid, s_tready;
    logic        clear, rd_en;
    logic [4:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [14:0] step_count;
    logic [31:0] total_spikes;
    logic        seq_error, done;

    // small instance signals
    logic [23:0] b_tdata;
    logic [8:0]  b_tuser;
    logic        b_tlast, b_tvalid, b_tready;
    logic        b_clear, b_rd_en;
    logic [4:0]  b_rd_addr;
    logic [7:0]  b_rd_data;
    logic        b_rd_valid;
    logic [8:0]  b_step;
    logic [31:0] b_total;
    logic        b_err, b_done;

    snn_spike_sink u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .step_count(step_count), .total_spikes(total_spikes),
        .seq_error(seq_error), .done(done)
    );

    snn_spike_sink #(.N(20), .T(1), .TS(300), .CW(8)) u_small (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(b_tdata), .s_axis_tuser(b_tuser), .s_axis_tlast(b_tlast),
        .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
        .clear(b_clear), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .step_count(b_step), .total_spikes(b_total),
        .seq_error(b_err), .done(b_done)
    );

    int          checks = 0;
    int          failures = 0;
    int          m_cnt [32];
    longint      m_total;
    int          m_step;
    bit          m_err;
    logic [15:0] sb [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_total = 0;
        m_step  = 0;
        m_err   = 1'b0;
    endtask

    // drive one beat from a negedge; returns at the negedge after the handshake
    task automatic beat(input logic [31:0] d, input int u, input bit l);
        int n = 0;
        s_tdata = d; s_tuser = 15'(u); s_tlast = l; s_tvalid = 1'b1;
        #1;
        while (!s_tready && n < 50) begin
            @(negedge aclk); #1; n++;
        end
        if (!s_tready) begin
            check("hs_timeout", 0, 1);
        end else begin
            @(posedge aclk);
            for (int i = 0; i < 32; i++)
                if (d[i] && m_cnt[i] < 65535) m_cnt[i]++;
            m_total += $countones(d);
            if (u != m_step + 1 || u == 0 || u > 29302) m_err = 1'b1;
            m_step = u;
        end
        @(negedge aclk);
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    // one-cycle read request with expected value queued
    task automatic rd(input int a);
        rd_en = 1'b1; rd_addr = 5'(a);
        sb.push_back(16'(m_cnt[a]));
        @(negedge aclk);
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge aclk);
        clear = 1'b0;
        @(negedge aclk);
        model_zero();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_total"}, total_spikes, 64'(m_total));
        check({tag, "_step"}, step_count, 64'(m_step));
        check({tag, "_seqerr"}, seq_error, 64'(m_err));
    endtask

    // read-data scoreboard: every rd_valid pops one expected value
    always @(negedge aclk) begin
        logic [15:0] e;
        if (aresetn && rd_valid) begin
            if (sb.size() == 0) begin
                check("rd_spurious", 1, 0);
            end else begin
                e = sb.pop_front();
                check("rd_data", rd_data, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        aresetn = 1'b0;
        s_tdata = '0; s_tuser = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
        clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
        b_tdata = '0; b_tuser = '0; b_tlast = 1'b0; b_tvalid = 1'b0;
        b_clear = 1'b0; b_rd_en = 1'b0; b_rd_addr = '0;
        model_zero();
        repeat (2) @(negedge aclk);

        // reset state
        check("rst_step", step_count, 0);
        check("rst_total", total_spikes, 0);
        check("rst_seqerr", seq_error, 0);
        check("rst_done", done, 0);
        check("rst_rdvalid", rd_valid, 0);
        check("rst_rddata", rd_data, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("rst_tready", s_tready, 1);

        // small instance: saturation at 255, ignored high bits, stop at tuser==TS
        for (int k = 1; k <= 300; k++) begin
            b_tdata = 24'hF00001; b_tuser = 9'(k); b_tvalid = 1'b1;
            @(negedge aclk);
        end
        b_tvalid = 1'b0;
        check("b_total", b_total, 300);
        check("b_step", b_step, 300);
        check("b_done", b_done, 1);
        check("b_tready", b_tready, 0);
        check("b_seqerr", b_err, 0);
        b_rd_en = 1'b1; b_rd_addr = 5'd0;
        @(posedge aclk); #1;
        check("b_rdvalid", b_rd_valid, 1);
        check("b_cnt0_sat", b_rd_data, 255);
        @(negedge aclk);
        b_rd_addr = 5'd25;
        @(posedge aclk); #1;
        check("b_rd_oor", b_rd_data, 0);
        @(negedge aclk);
        b_rd_en = 1'b0;

        // three beats ending with tlast
        beat(32'h1, 1, 0);
        beat(32'h3, 2, 0);
        beat(32'h8000_0001, 3, 1);
        check("t1_total", total_spikes, 5);
        check("t1_step", step_count, 3);
        check("t1_done", done, 1);
        check("t1_tready", s_tready, 0);
        check("t1_seqerr", seq_error, 0);
        check("t1_m_cnt0", 64'(m_cnt[0]), 3);
        rd(0); rd(1); rd(31); rd(2);
        @(negedge aclk);
        check("t1_rdvalid_idle", rd_valid, 0);

        // sequence gap 1,2,4 then clear
        do_clear();
        check("t2_tready_after_clr", s_tready, 1);
        check("t2_done_after_clr", done, 0);
        beat(32'h5, 1, 0);
        beat(32'h5, 2, 0);
        check("t2_seqerr_before", seq_error, 0);
        beat(32'h2, 4, 0);
        check("t2_seqerr_after", seq_error, 1);
        check_status("t2");
        rd(0); rd(1); rd(2);
        @(negedge aclk);
        do_clear();
        check("t2_clr_seqerr", seq_error, 0);
        check("t2_clr_total", total_spikes, 0);
        check("t2_clr_tready", s_tready, 1);
        rd(0); rd(2);

        // clear coincident with a valid beat; beat held and taken after CLR
        beat(32'h10, 1, 0);
        clear = 1'b1;
        s_tdata = 32'h0000_0110; s_tuser = 15'd1; s_tvalid = 1'b1;
        #1;
        check("t4_tready_clear", s_tready, 0);
        @(negedge aclk);
        clear = 1'b0;
        check("t4_tready_clr_state", s_tready, 0);
        rd_en = 1'b1; rd_addr = 5'd4;
        sb.push_back(16'(m_cnt[4]));
        @(negedge aclk);
        rd_en = 1'b0;
        model_zero();
        beat(32'h0000_0110, 1, 0);
        check_status("t4");
        rd(4); rd(8);

        // read-before-write on a same-cycle handshake
        @(negedge aclk);
        rd_en = 1'b1; rd_addr = 5'd0;
        sb.push_back(16'(m_cnt[0]));
        beat(32'h1, m_step + 1, 0);
        sb.push_back(16'(m_cnt[0]));
        @(negedge aclk);
        rd_en = 1'b0;
        @(negedge aclk);

        // random gaps and data, then back-to-back read sweep
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge aclk);
            d = $urandom;
            if (k == 0) d = d | 32'h1;
            beat(d, m_step + 1, 0);
        end
        check_status("t6");
        for (int i = 0; i < 32; i++) begin
            rd_en = 1'b1; rd_addr = 5'(i);
            sb.push_back(16'(m_cnt[i]));
            @(negedge aclk);
        end
        rd_en = 1'b0;
        @(negedge aclk);
        check("t6_sb_drained", 64'(sb.size()), 0);

        // asynchronous reset mid-run with a read result and a beat in flight
        rd_en = 1'b1; rd_addr = 5'd0;
        s_tdata = 32'hFFFF; s_tuser = 15'(m_step + 1); s_tvalid = 1'b1;
        @(posedge aclk); #2;
        check("t6_rdvalid_pre", rd_valid, 1);
        aresetn = 1'b0;
        #1;
        check("t6_arst_step", step_count, 0);
        check("t6_arst_total", total_spikes, 0);
        check("t6_arst_seqerr", seq_error, 0);
        check("t6_arst_done", done, 0);
        check("t6_arst_rdvalid", rd_valid, 0);
        check("t6_arst_rddata", rd_data, 0);
        check("t6_arst_b_total", b_total, 0);
        check("t6_arst_tready", s_tready, 1);
        rd_en = 1'b0; s_tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        model_zero();
        @(negedge aclk);
        rd(0); rd(31);
        beat(32'h1, 1, 0);
        check_status("t6_restart");
        @(negedge aclk);
        check("final_sb_drained", 64'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
